// File: rtl/keypad_number_entry.sv
// rtl/keypad_number_entry.sv - assembles a signed decimal number from scanner key strobes
module keypad_number_entry #(
    parameter int MAX_DIGITS     = 3,
    parameter int WIDTH          = 11,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                    clk_div,
    input  logic                    rst,
    input  logic [3:0]              num,
    input  logic [1:0]              load_num,
    output logic [WIDTH-1:0]        value_out,
    output logic                    value_valid,
    output logic [4*MAX_DIGITS-1:0] bcd_digits,
    output logic                    neg,
    output logic [1:0]              digit_count,
    output logic                    busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ENTRY = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int ACC_W = WIDTH - 1;
    localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);

    localparam logic [3:0] KEY_SIGN  = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;
    localparam logic [3:0] KEY_CLEAR = 4'd12;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic             armed;
    logic [CNT_W-1:0] rel_cnt;
    logic             accept;
    logic [ACC_W-1:0] acc_shifted;
    logic [ACC_W-1:0] digit_ext;
    logic             digit_room;

    assign accept      = load_num[0] & armed;
    assign digit_ext   = {{(ACC_W-4){1'b0}}, num};
    assign acc_shifted = acc * ACC_W'(10) + digit_ext;
    assign digit_room  = digit_count < 2'(MAX_DIGITS);
    assign busy        = (state == ENTRY);

    // Debounce gate: one accepted key per press, re-armed after a run of idle strobe cycles
    always_ff @(posedge clk_div) begin
        if (rst) begin
            armed   <= 1'b1;
            rel_cnt <= '0;
        end else if (accept) begin
            armed   <= 1'b0;
            rel_cnt <= '0;
        end else if (load_num[0]) begin
            rel_cnt <= '0;
        end else if (rel_cnt != CNT_W'(RELEASE_CYCLES)) begin
            rel_cnt <= rel_cnt + 1'b1;
            if (rel_cnt + 1'b1 == CNT_W'(RELEASE_CYCLES)) begin
                armed <= 1'b1;
            end
        end
    end

    // Entry state machine: digit accumulation, sign, enter and clear on accepted keys
    always_ff @(posedge clk_div) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            value_out   <= '0;
            value_valid <= 1'b0;
            bcd_digits  <= '0;
            neg         <= 1'b0;
            digit_count <= 2'd0;
        end else begin
            value_valid <= 1'b0;
            if (accept) begin
                if (num <= 4'd9) begin
                    if (state != ENTRY) begin
                        bcd_digits  <= {{(4*MAX_DIGITS-4){1'b0}}, num};
                        acc         <= digit_ext;
                        digit_count <= 2'd1;
                        state       <= ENTRY;
                        if (state == DONE) begin
                            neg <= 1'b0;
                        end
                    end else if (digit_room) begin
                        bcd_digits  <= {bcd_digits[4*MAX_DIGITS-5:0], num};
                        acc         <= acc_shifted;
                        digit_count <= digit_count + 2'd1;
                    end
                end else if (num == KEY_SIGN) begin
                    if (state == DONE) begin
                        neg         <= 1'b1;
                        bcd_digits  <= '0;
                        acc         <= '0;
                        digit_count <= 2'd0;
                    end else begin
                        neg <= ~neg;
                    end
                    state <= ENTRY;
                end else if (num == KEY_ENTER) begin
                    if (state == ENTRY && digit_count != 2'd0) begin
                        value_out   <= neg ? -{1'b0, acc} : {1'b0, acc};
                        value_valid <= 1'b1;
                        state       <= DONE;
                        // a negative zero is published and displayed as plain zero
                        if (acc == '0) begin
                            neg <= 1'b0;
                        end
                    end
                end else if (num == KEY_CLEAR) begin
                    bcd_digits  <= '0;
                    neg         <= 1'b0;
                    digit_count <= 2'd0;
                    acc         <= '0;
                    state       <= IDLE;
                end
            end
        end
    end
endmodule

// File: doc/keypad_number_entry.md
Name: keypad_number_entry

Overview:
- Downstream consumer of the 4x4 keypad scanner.
- Takes the scanner's key code (num) and load strobe (load_num) and assembles a signed decimal number of up to MAX_DIGITS digits.
- Key functions: digit keys 0-9, A = sign toggle, B = enter, C = clear.
- On enter, publishes the signed binary value with a one-cycle valid pulse, and drives BCD digits plus a sign flag for the display stage.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits accepted per number.
- WIDTH, 11, width of signed two's-complement value_out; must hold ±(10^MAX_DIGITS - 1).
- RELEASE_CYCLES, 4, consecutive clk_div cycles with load_num[0]=0 required before a new key is accepted.

Ports:
- clk_div  in  1  scan/system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- num  in  4  key code from the scanner: 0-9 digit, 10 = A (sign), 11 = B (enter), 12 = C (clear), 13-15 unused.
- load_num  in  2  key strobe from the scanner; only bit 0 is used, bit 1 is ignored.
- value_out  out  WIDTH  signed value of the last entered number.
- value_valid  out  1  one-cycle pulse when value_out is updated.
- bcd_digits  out  4*MAX_DIGITS  BCD digits being entered, least significant digit in [3:0].
- neg  out  1  current sign of the entry (1 = negative).
- digit_count  out  2  number of digits entered (0..MAX_DIGITS).
- busy  out  1  high while in ENTRY state.

Behaviour:
- Reset (rst=1 at clk_div edge):
  - value_out=0, value_valid=0, bcd_digits=0, neg=0, digit_count=0, busy=0.
  - state=IDLE, accumulator=0, armed=1, release counter=0.
- Key acceptance gate:
  - The scanner re-strobes load_num every ~2 cycles while a key is held, so strobes are gated.
  - accept = load_num[0] & armed.
  - On accept: armed<=0, release counter<=0.
  - While load_num[0]=0: counter increments, saturating at RELEASE_CYCLES.
  - armed<=1 when the counter reaches RELEASE_CYCLES.
  - Any load_num[0]=1 while not armed resets the counter to 0.
  - num is sampled only on the accept edge.
- Latency: all register updates happen on the same clk_div edge where accept=1; outputs are visible the following cycle.
- States: IDLE (no digits), ENTRY (≥1 digit or sign set), DONE (value published).
- Digit d (0-9):
  - From IDLE or DONE: start a fresh number. bcd_digits={0..,d}, accumulator=d, digit_count=1. neg is kept if coming from IDLE, cleared if coming from DONE. Go to ENTRY.
  - From ENTRY with digit_count<MAX_DIGITS: bcd_digits shift left by 4 with d inserted at [3:0]; accumulator=accumulator*10+d; digit_count+1.
  - From ENTRY with digit_count=MAX_DIGITS: key ignored, no change.
- A (sign toggle):
  - neg toggles in IDLE or ENTRY; IDLE goes to ENTRY with digit_count=0.
  - In DONE: neg<=1, digits cleared, go to ENTRY.
- B (enter):
  - Only when in ENTRY with digit_count≥1.
  - value_out = neg ? -accumulator : accumulator; value_valid=1 for exactly one cycle; go to DONE.
  - bcd_digits, neg and digit_count hold in DONE for display.
  - Negative zero publishes value_out=0 and clears neg.
  - B in IDLE, in DONE, or in ENTRY with 0 digits: ignored, no pulse.
- C (clear):
  - From any state: bcd_digits=0, neg=0, digit_count=0, accumulator=0, go to IDLE.
  - value_out keeps its last published value.
- Codes 13-15: accepted (consume armed) but otherwise ignored.
- busy=1 exactly in ENTRY.
- value_valid is never asserted on two consecutive cycles.
- Reset mid-entry or coincident with accept: reset wins, the key is lost.
- Accumulator width: WIDTH-1 unsigned bits; no overflow is possible given the MAX_DIGITS cap.

Test Plan:
- Reset, then keys 1,2,3,B (each load_num pulse separated by ≥RELEASE_CYCLES idle cycles) -> bcd_digits=0x123, value_out=123, one value_valid pulse, state DONE.
- Keys A,4,5,B -> neg=1, value_out=-45 (11'h7D3), value_valid single pulse.
- Keys 9,9,9,7,B -> fourth digit ignored, digit_count=3, value_out=999.
- Hold key 5 with load_num toggling 1,0,1,0 for 20 cycles, then release -> only one digit 5 captured; the next press after 4 low cycles is accepted.
- Keys 6,C,B -> IDLE, no value_valid pulse, value_out unchanged; then keys A,0,B -> value_out=0, neg=0.
- After DONE with 123, key 7 -> new entry bcd_digits=0x007, neg=0, busy=1; assert rst during entry -> all outputs 0 the next cycle.
